// File: rtl/mac8_pkg.sv
// mac8_pkg: shared widths and types for the mac_8 multiply-accumulate slice.
//   IN_W  : operand width (8)
//   ACC_W : accumulator width, always 2*IN_W so the exact product fits
//   operand_t / acc_t : operand and accumulator vector types
package mac8_pkg;
    localparam int IN_W  = 8;
    localparam int ACC_W = 16;
    typedef logic [IN_W-1:0]  operand_t;
    typedef logic [ACC_W-1:0] acc_t;
endpackage

// File: rtl/mac8_mult.sv
// mac8_mult: combinational unsigned IN_W x IN_W -> ACC_W array multiplier.
//   a, b : unsigned operands
//   p    : exact product (never exceeds ACC_W bits)
// Partial products are summed by a balanced adder tree stored in heap order:
// node k has children 2k+1 and 2k+2, leaves sit at IN_W-1 .. 2*IN_W-2.
module mac8_mult
    import mac8_pkg::*;
(
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] p
);
    acc_t node [2*IN_W-1];
    for (genvar i = 0; i < IN_W; i++) begin : g_pp
        assign node[IN_W-1+i] = b[i] ? acc_t'(a) << i : '0;
    end
    for (genvar k = 0; k < IN_W-1; k++) begin : g_tree
        assign node[k] = node[2*k+1] + node[2*k+2];
    end
    assign p = node[0];
endmodule

// File: rtl/mac_8.sv
// mac_8: unsigned 8x8 multiply-accumulate with 16-bit wrapping accumulator.
//   clk   : rising-edge clock
//   reset : synchronous active-high, clears s and carry (priority over a/b)
//   a, b  : operands, accumulated as a*b on every non-reset edge
//   s     : registered accumulator, wraps modulo 2^ACC_W
//   carry : registered carry-out of the latest accumulation
// Optional macro MAC8_STICKY_CARRY_EN: carry holds once set until reset.
module mac_8
    import mac8_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] s,
    output logic             carry
);
    acc_t prod;
    logic [ACC_W:0] sum;
    logic carry_nxt;
    mac8_mult u_mult (.a(a), .b(b), .p(prod));
    assign sum = {1'b0, s} + {1'b0, prod};
`ifdef MAC8_STICKY_CARRY_EN
    assign carry_nxt = carry | sum[ACC_W];
`else
    assign carry_nxt = sum[ACC_W];
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            s     <= '0;
            carry <= 1'b0;
        end else begin
            s     <= sum[ACC_W-1:0];
            carry <= carry_nxt;
        end
    end
endmodule

// File: tb/tb_mac_8.sv
// tb_mac_8: scoreboard bench for mac_8; expected s/carry come from a
// reference accumulator computed when each stimulus is driven.
module tb_mac_8;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [15:0] s;
    logic        carry;
    typedef struct {
        logic [15:0] s;
        logic        c;
    } exp_t;
    exp_t        sb [$];
    int          compared = 0;
    int          mismatched = 0;
    logic [15:0] ms = '0;
    logic        mc = 1'b0;
    logic        sticky;

    always #5 clk = ~clk;

    mac_8 dut (.clk(clk), .reset(reset), .a(a), .b(b), .s(s), .carry(carry));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [7:0] x, input logic [7:0] y);
        logic [16:0] t;
        exp_t e;
        reset = r;
        a = x;
        b = y;
        if (r) begin
            ms = '0;
            mc = 1'b0;
        end else begin
            t  = {1'b0, ms} + 17'(x) * 17'(y);
            ms = t[15:0];
            mc = sticky ? (mc | t[16]) : t[16];
        end
        e.s = ms;
        e.c = mc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("s", s, e.s);
            check("carry", carry, e.c);
        end
    endtask

    initial begin
`ifdef MAC8_STICKY_CARRY_EN
        sticky = 1'b1;
`else
        sticky = 1'b0;
`endif
        step(1, 8'hFF, 8'hFF);
        check("rst_s", s, 0);
        check("rst_carry", carry, 0);
        step(1, 8'hFF, 8'hFF);
        check("rst2_s", s, 0);
        for (int i = 0; i < 9; i++) step(0, 8'(2*i+1), 8'(2*i+2));
        check("seq_1050", s, 1050);
        check("seq_carry", carry, 0);
        for (int i = 0; i < 3; i++) step(0, 8'd127, 8'd127);
        check("s_49437", s, 49437);
        step(0, 8'd127, 8'd127);
        check("wrap_30", s, 30);
        check("wrap_carry", carry, 1);
        step(0, 8'd0, 8'd0);
        check("hold_30", s, 30);
        check("hold_carry", carry, sticky ? 1 : 0);
        step(1, 8'd9, 8'd9);
        step(0, 8'hFF, 8'hFF);
        check("max_once", s, 65025);
        step(1, 8'hFF, 8'hFF);
        check("midrst_s", s, 0);
        check("midrst_carry", carry, 0);
        step(0, 8'd2, 8'd3);
        check("restart_6", s, 6);
        step(1, 8'd0, 8'd0);
        step(0, 8'hFF, 8'hFF);
        step(0, 8'hFF, 8'hFF);
        check("max_twice", s, 64514);
        check("max_carry", carry, 1);
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 15) == 0, 8'($urandom), 8'($urandom));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
